// File: rtl/icache_pkg.sv
// Shared types and address-field constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int SETS_DEF  = 16;
    localparam int WORDS_DEF = 4;

    localparam int WORD_LO = 2;
    localparam int WORD_HI = 3;
    localparam int IDX_LO  = 4;
    localparam int IDX_HI  = 7;
    localparam int TAG_LO  = 8;
    localparam int TAG_HI  = 31;

    localparam int IDX_W  = IDX_HI - IDX_LO + 1;
    localparam int TAG_W  = TAG_HI - TAG_LO + 1;
    localparam int LINE_W = 32 - IDX_LO;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_RESUME = 2'd2
    } state_e;

endpackage

// File: rtl/icache_if.sv
// Word-read memory bus: the cache side is master, the memory side is slave.
interface icache_mem_if;

    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output req, output addr, input rdata, input rvalid);
    modport slave  (input req, input addr, output rdata, output rvalid);

endinterface

// File: rtl/icache_refill_ctrl.sv
// Line refill sequencer: four in-order word reads with a req/rvalid handshake.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [LINE_W-1:0] line_i,
    icache_mem_if.master      mem,
    output logic [1:0]        beat_o,
    output logic              wr_o,
    output logic              done_o,
    output logic [LINE_W-1:0] line_o
);

    logic              req_q, req_d;
    logic [1:0]        beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              ack;

    assign ack      = req_q && mem.rvalid;
    assign mem.req  = req_q;
    assign mem.addr = {line_q, beat_q, 2'b00};
    assign beat_o   = beat_q;
    assign wr_o     = ack;
    assign done_o   = ack && (beat_q == 2'd3);
    assign line_o   = line_q;

    always_comb begin
        req_d  = req_q;
        beat_d = beat_q;
        line_d = line_q;
        if (start_i) begin
            req_d  = 1'b1;
            beat_d = 2'd0;
            line_d = line_i;
        end else if (ack) begin
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
                req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= 1'b0;
            beat_q <= 2'd0;
            line_q <= '0;
        end else begin
            req_q  <= req_d;
            beat_q <= beat_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with one-cycle hit latency and
// blocking refill; a redirect seen during refill is replayed afterwards.
module icache
    import icache_pkg::*;
#(
    parameter int SETS  = SETS_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc_icache_i,
    input  logic        if_req_icache_i,
    input  logic        if_jump_icache_i,
    output logic [31:0] icache_inst_o,
    output logic        icache_inst_valid_o,
    output logic        icache_busy_fc_o,
    output logic        icache_req_again_if_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i
);

    icache_mem_if mem_if ();

    assign mem_req_o     = mem_if.req;
    assign mem_addr_o    = mem_if.addr;
    assign mem_if.rdata  = mem_rdata_i;
    assign mem_if.rvalid = mem_rvalid_i;

    state_e            state_q, state_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic              pend_q, pend_d;
    logic [31:0]       pend_pc_q, pend_pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;

    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS][WORDS];

    logic [31:0]       lk_pc;
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [1:0]        lk_word;
    logic              lk_go;
    logic              hit;
    logic              start;

    logic [1:0]        fill_beat;
    logic              fill_wr;
    logic              fill_done;
    logic [LINE_W-1:0] fill_line;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              unused_bits;

    icache_refill_ctrl u_refill (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .line_i  (lk_pc[31:IDX_LO]),
        .mem     (mem_if.master),
        .beat_o  (fill_beat),
        .wr_o    (fill_wr),
        .done_o  (fill_done),
        .line_o  (fill_line)
    );

    // In RESUME the lookup port is borrowed by the replayed redirect.
    assign lk_pc   = (state_q == S_RESUME) ? pend_pc_q : if_pc_icache_i;
    assign lk_idx  = lk_pc[IDX_HI:IDX_LO];
    assign lk_tag  = lk_pc[TAG_HI:TAG_LO];
    assign lk_word = lk_pc[WORD_HI:WORD_LO];
    assign lk_go   = ((state_q == S_IDLE) && if_req_icache_i)
                  || ((state_q == S_RESUME) && pend_q);
    assign hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign fill_idx    = fill_line[IDX_W-1:0];
    assign fill_tag    = fill_line[LINE_W-1:IDX_W];
    assign unused_bits = ^lk_pc[1:0];

    assign icache_inst_o         = inst_q;
    assign icache_inst_valid_o   = inst_valid_q;
    assign icache_busy_fc_o      = (state_q == S_REFILL);
    assign icache_req_again_if_o = (state_q == S_RESUME) && !pend_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        start        = 1'b0;
        inst_valid_d = lk_go && hit;
        inst_d       = (lk_go && hit) ? data_q[lk_idx][lk_word] : inst_q;
        unique case (state_q)
            S_IDLE: begin
                if (lk_go && !hit) begin
                    start   = 1'b1;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (if_req_icache_i && if_jump_icache_i) begin
                    pend_d    = 1'b1;
                    pend_pc_d = if_pc_icache_i;
                end
                if (fill_done) begin
                    valid_d[fill_idx] = 1'b1;
                    state_d           = S_RESUME;
                end
            end
            S_RESUME: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
                if (lk_go && !hit) begin
                    start   = 1'b1;
                    state_d = S_REFILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (fill_wr && !rst) begin
            data_q[fill_idx][fill_beat] <= mem_if.rdata;
        end
        if (fill_done && !rst) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (rising edge only); rst, sampled on clk, active-high, synchronous.
REQ-002 SHALL use these parameters (name, default, meaning):
- SETS, 16, number of direct-mapped lines.
- WORDS, 4, 32-bit words per line.
REQ-003 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_pc_icache_i  in  32  fetch address
- if_req_icache_i  in  1  fetch request, one cycle per request
- if_jump_icache_i  in  1  request is a redirect target
- icache_inst_o  out  32  fetched instruction
- icache_inst_valid_o  out  1  icache_inst_o valid this cycle
- icache_busy_fc_o  out  1  miss in progress; fc holds the fetch PC
- icache_req_again_if_o  out  1  one-cycle pulse: IF reissues the held PC
- mem_req_o  out  1  memory word read request
- mem_addr_o  out  32  word-aligned memory address
- mem_rdata_i  in  32  memory read data
- mem_rvalid_i  in  1  mem_rdata_i valid; completes the current beat

Function
REQ-004 SHALL split the address as follows: [1:0] ignored; [3:2] word; [7:4] index; [31:8] tag (24 bits).
REQ-005 SHALL hold per line a valid bit, a 24-bit tag and 4 data words, all registers.
REQ-006 SHALL implement the states IDLE, REFILL and RESUME.
REQ-007 In IDLE, a request with valid and matching tag (hit) SHALL give icache_inst_o equal to the addressed word and icache_inst_valid_o=1 on the next cycle (latency 1); the state stays IDLE.
REQ-008 In IDLE, a request that misses SHALL latch PC, tag, index and word, go to REFILL, and drive icache_busy_fc_o=1 from the next cycle until it leaves REFILL; icache_inst_valid_o stays 0 for a missing request.
REQ-009 In REFILL, the block SHALL read 4 beats in order, beat 0..3.
- Beat address: {tag, index, beat[1:0], 2'b00}.
- mem_req_o and mem_addr_o are held stable until mem_rvalid_i=1.
- On mem_rvalid_i=1 the word is written to the line and the 2-bit beat counter advances.
- mem_req_o drops in the cycle after the beat-3 acknowledge.
REQ-010 On the beat-3 acknowledge, the block SHALL set the line valid, write the tag, and go to RESUME.
REQ-011 In RESUME (one cycle), with no pending jump, the block SHALL assert icache_req_again_if_o=1 for exactly that cycle and return to IDLE; the reissued request then hits.
REQ-012 During REFILL, requests without if_jump_icache_i SHALL be ignored.
REQ-013 A request with if_jump_icache_i=1 during REFILL SHALL be latched as pending; a later jump overwrites it.
REQ-014 With a pending jump, RESUME SHALL suppress icache_req_again_if_o and perform the lookup of the pending PC per REQ-007/REQ-008.
REQ-015 A refill SHALL never be aborted; a line fetched for a PC superseded by a jump is still installed.
REQ-016 A request in the same cycle as rst SHALL be dropped.
REQ-017 icache_inst_valid_o SHALL be a single-cycle pulse per serviced request.
REQ-018 icache_inst_o SHALL hold its last value when icache_inst_valid_o=0.

Reset
REQ-019 On rst, the block SHALL:
- clear all valid bits;
- set state=IDLE, beat=0 and pending=0;
- drive icache_inst_o=0, icache_inst_valid_o=0, icache_busy_fc_o=0, icache_req_again_if_o=0, mem_req_o=0 and mem_addr_o=0.
REQ-020 Tag and data arrays SHALL NOT be reset.
REQ-021 rst during REFILL SHALL abandon the refill immediately, leaving the line invalid.

Structure
REQ-022 A shared package SHALL hold the state enum, the index/word/tag bit-range constants and the SETS/WORDS defaults.
REQ-023 A single sub-module, icache_refill_ctrl (beat counter plus memory handshake), SHALL be instantiated; the tag/data arrays and lookup stay in icache.

Verification
REQ-024 Cold miss: request PC=0x00000104 with memory returning 0xA0..0xA3 -> 4 beats at 0x100, 0x104, 0x108 and 0x10C, busy=1 throughout, req_again pulse; reissued PC=0x104 -> inst=0xA1, valid on the next cycle.
REQ-025 Hit stream: PCs 0x100, 0x104, 0x108 and 0x10C on consecutive cycles after the fill -> inst 0xA0..0xA3, one per cycle, with no memory requests.
REQ-026 Conflict: PC 0x1100 (same index 0, different tag) after line 0x100 is filled -> miss and refill; a later access to 0x100 misses again.
REQ-027 Jump during refill: jump request PC=0x200 at beat 2 -> refill completes, no req_again, then lookup and miss refill of 0x200.
REQ-028 Memory stall: mem_rvalid_i held low 5 cycles on beat 1 -> mem_addr_o stays 0x104 and mem_req_o stays 1.
REQ-029 Reset mid-refill: rst at beat 2 -> all outputs 0 next cycle; a request to the same PC misses.
